// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default operand
// width, iteration count, FSM state encoding and operation-type encoding.
package mult_div_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned ITER_COUNT    = WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign fixup for the multiply/divide unit.
// Ports:
//   raw_i    - unsigned 2*WIDTH result of the magnitude datapath
//              (multiply: product; divide: {remainder, quotient})
//   op_i     - operation type (OP_MULT / OP_DIV)
//   sign_a_i - sign of the original a operand
//   sign_b_i - sign of the original b operand
//   dz_i     - divide with a zero divisor
//   hi_o     - final HI (product upper half / signed remainder / a on div-by-0)
//   lo_o     - final LO (product lower half / signed quotient / all ones on div-by-0)
module mdu_sign_fix
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [2*WIDTH-1:0] raw_i,
  input  logic               op_i,
  input  logic               sign_a_i,
  input  logic               sign_b_i,
  input  logic               dz_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  always_comb begin
    rem  = raw_i[2*WIDTH-1:WIDTH];
    quo  = raw_i[WIDTH-1:0];
    hi_o = rem;
    lo_o = quo;
    if (op_i == OP_MULT) begin
      if (sign_a_i ^ sign_b_i) begin
        {hi_o, lo_o} = -raw_i;
      end
    end else begin
      // With a zero divisor every trial subtract succeeds, so the remainder
      // path collects |a| unchanged; re-signing it restores the original a.
      hi_o = sign_a_i ? -rem : rem;
      lo_o = (sign_a_i ^ sign_b_i) ? -quo : quo;
      if (dz_i) begin
        lo_o = '1;
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit with fixed 33-cycle start-to-done
// latency. Both operations share one 64-bit left-shifting accumulator.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   mult_start - one-cycle pulse, start signed a * b
//   div_start  - one-cycle pulse, start signed a / b (multiply wins if both)
//   a, b       - operands, sampled only on an accepted start
//   hi_out     - product upper half or remainder
//   lo_out     - product lower half or quotient
//   mult_done  - one-cycle pulse, multiply result valid
//   div_done   - one-cycle pulse, divide result valid
//   busy       - high from the cycle after an accepted start through done
//   div_zero   - set with div_done for a zero divisor, held until next start
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_done,
  output logic             div_done,
  output logic             busy,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   src_q;   // bit source, consumed MSB first
  logic [WIDTH-1:0]   oth_q;   // addend (multiply) or divisor (divide)
  logic               sign_a_q;
  logic               sign_b_q;
  logic               dz_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  // Multiply: acc = 2*acc + (bit ? |a| : 0), multiplier bits MSB first.
  // Divide: acc = {rem, quo}; the next dividend bit enters at the remainder
  // LSB (the displaced acc[WIDTH-1] is always a not-yet-used zero), then a
  // trial subtract of |b| decides the new quotient bit.
  always_comb begin
    shifted = {acc_q[2*WIDTH-2:0], 1'b0};
    if (op_q == OP_DIV) begin
      shifted[WIDTH] = src_q[WIDTH-1];
    end
    trial = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, oth_q};
    acc_d = shifted;
    if (op_q == OP_MULT) begin
      if (src_q[WIDTH-1]) begin
        acc_d = shifted + {{WIDTH{1'b0}}, oth_q};
      end
    end else if (!trial[WIDTH]) begin
      acc_d = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end
  end

  mdu_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .raw_i   (acc_d),
    .op_i    (op_q),
    .sign_a_i(sign_a_q),
    .sign_b_i(sign_b_q),
    .dz_i    (dz_q),
    .hi_o    (fix_hi),
    .lo_o    (fix_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      src_q     <= '0;
      oth_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      hi_out    <= '0;
      lo_out    <= '0;
      mult_done <= 1'b0;
      div_done  <= 1'b0;
      busy      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      mult_done <= 1'b0;
      div_done  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mult_start || div_start) begin
            op_q     <= mult_start ? OP_MULT : OP_DIV;
            src_q    <= mult_start ? abs_b : abs_a;
            oth_q    <= mult_start ? abs_a : abs_b;
            sign_a_q <= a[WIDTH-1];
            sign_b_q <= b[WIDTH-1];
            dz_q     <= !mult_start && (b == '0);
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          src_q <= {src_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            hi_out    <= fix_hi;
            lo_out    <= fix_lo;
            mult_done <= (op_q == OP_MULT);
            div_done  <= (op_q == OP_DIV);
            div_zero  <= dz_q;
            state_q   <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        mult_done;
  logic        div_done;
  logic        busy;
  logic        div_zero;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mult_start(mult_start),
    .div_start (div_start),
    .a         (a),
    .b         (b),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .mult_done (mult_done),
    .div_done  (div_done),
    .busy      (busy),
    .div_zero  (div_zero)
  );

  typedef struct {
    bit          is_div;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit is_div, input logic [31:0] av,
                                 input logic [31:0] bv, input int t0);
    exp_t   e;
    longint p;
    int     q;
    int     r;
    e.is_div = is_div;
    e.dz     = 1'b0;
    e.t0     = t0;
    if (!is_div) begin
      p    = longint'($signed(av)) * longint'($signed(bv));
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (bv == 32'h0) begin
      e.hi = av;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
      e.hi = 32'h0;
      e.lo = 32'h8000_0000;
    end else begin
      q    = $signed(av) / $signed(bv);
      r    = $signed(av) % $signed(bv);
      e.hi = r;
      e.lo = q;
    end
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (mult_done || div_done)) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_kind", {62'd0, mult_done, div_done}, e.is_div ? 64'd1 : 64'd2);
        check("latency", 64'(cyc - e.t0), 64'd33);
        check("hi_out", {32'd0, hi_out}, {32'd0, e.hi});
        check("lo_out", {32'd0, lo_out}, {32'd0, e.lo});
        check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
        check("busy_at_done", {63'd0, busy}, 64'd1);
      end
    end
  end

  // Drive a start from IDLE; the accepted op is pushed to the scoreboard.
  task automatic start_op(input bit m, input bit d, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    mult_start = m;
    div_start  = d;
    a = av;
    b = bv;
    sb.push_back(model(!m, av, bv, cyc));
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("timeout_pending", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h0;
    logic [31:0] l0;
    int          changes;
    int          done0;
    bit          rd;

    reset = 1'b1;
    mult_start = 1'b0;
    div_start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", {32'd0, hi_out}, 64'd0);
    check("rst_lo", {32'd0, lo_out}, 64'd0);
    check("rst_done", {62'd0, mult_done, div_done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_div_zero", {63'd0, div_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    start_op(1, 0, 32'd7, 32'hFFFF_FFFD);
    wait_idle();
    start_op(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_idle();
    start_op(0, 1, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    start_op(0, 1, 32'd100, 32'd0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("div_zero_held", {63'd0, div_zero}, 64'd1);
    start_op(1, 0, 32'd3, 32'd9);
    check("div_zero_cleared", {63'd0, div_zero}, 64'd0);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_idle();

    // Simultaneous starts: multiply wins.
    start_op(1, 1, 32'd3, 32'd4);
    wait_idle();

    // Starts during RUN and DONE are ignored; outputs hold during RUN.
    done0 = n_done;
    start_op(1, 0, 32'd12345, 32'hFFFF_FD5A);
    h0 = hi_out;
    l0 = lo_out;
    changes = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 32 && (hi_out !== h0 || lo_out !== l0)) changes++;
      if (k == 33) check("busy_T33", {63'd0, busy}, 64'd1);
      if (k == 34) check("busy_T34", {63'd0, busy}, 64'd0);
      div_start  = (k == 10);
      mult_start = (k == 33);
      a = 32'd99;
      b = 32'd0;
    end
    mult_start = 1'b0;
    div_start  = 1'b0;
    check("outputs_held_in_run", 64'(changes), 64'd0);
    check("single_done", 64'(n_done - done0), 64'd1);
    wait_idle();

    // A few random operations.
    for (int i = 0; i < 8; i++) begin
      rd = 1'($urandom_range(0, 1));
      start_op(!rd, rd, $urandom, (i < 4) ? 32'($urandom_range(1, 50)) : $urandom);
      wait_idle();
    end

    // Reset mid-divide: outputs clear at once and no done follows.
    done0 = n_done;
    start_op(0, 1, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    check("abort_hi", {32'd0, hi_out}, 64'd0);
    check("abort_lo", {32'd0, lo_out}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_flags", {61'd0, mult_done, div_done, div_zero}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 64'(n_done - done0), 64'd0);
    check("idle_after_abort", {63'd0, busy}, 64'd0);
    start_op(1, 0, 32'd5, 32'd6);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
